// File: rtl/adder_share_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing one WIDTH-bit ripple adder among 4 requesters.
// Latency: grant on sampling edge 0, done pulses after edge SETTLE_CYCLES, next arbitration at SETTLE_CYCLES+2.
// Backpressure: level req is held by each requester until its done; losers simply wait their round-robin turn.
module adder_share_arbiter #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  input  logic [3:0]         cin_in,
  output logic [3:0]         grant,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               cout,
  output logic               busy,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter is loaded with SETTLE_CYCLES-1 so sampling lands exactly SETTLE_CYCLES edges after grant.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_d;
  logic [1:0]       rr_ptr, rr_ptr_d;
  logic [3:0]       cnt, cnt_d;
  logic [3:0]       grant_d;
  logic             done_d;
  logic [WIDTH-1:0] result_d;
  logic             cout_d;
  logic             busy_d;
  logic [WIDTH-1:0] add_a_d;
  logic [WIDTH-1:0] add_b_d;
  logic             add_cin_d;

  logic [3:0]       req_rot;
  logic             win_vld;
  logic [1:0]       win_off;
  logic [1:0]       win_idx;

  // Rotate requests so bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < 4; i++) begin
      req_rot[i] = req[rr_ptr + 2'(i)];
    end
    win_vld = |req_rot;
    win_off = 2'd0;
    if (req_rot[0])      win_off = 2'd0;
    else if (req_rot[1]) win_off = 2'd1;
    else if (req_rot[2]) win_off = 2'd2;
    else if (req_rot[3]) win_off = 2'd3;
    win_idx = rr_ptr + win_off;
  end

  // Next-state and next-output logic; everything holds unless the current state says otherwise.
  always_comb begin
    state_d   = state;
    rr_ptr_d  = rr_ptr;
    cnt_d     = cnt;
    grant_d   = grant;
    done_d    = 1'b0;
    result_d  = result;
    cout_d    = cout;
    busy_d    = busy;
    add_a_d   = add_a;
    add_b_d   = add_b;
    add_cin_d = add_cin;
    case (state)
      IDLE: begin
        if (win_vld) begin
          grant_d   = 4'b0001 << win_idx;
          add_a_d   = a_in[win_idx*WIDTH +: WIDTH];
          add_b_d   = b_in[win_idx*WIDTH +: WIDTH];
          add_cin_d = cin_in[win_idx];
          cnt_d     = CNT_INIT;
          busy_d    = 1'b1;
          rr_ptr_d  = win_idx + 2'd1;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        // Adder inputs stay frozen while the ripple chain settles.
        if (cnt != 4'd0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          result_d = add_sum;
          cout_d   = add_cout;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      cnt     <= '0;
      grant   <= '0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
    end else begin
      state   <= state_d;
      rr_ptr  <= rr_ptr_d;
      cnt     <= cnt_d;
      grant   <= grant_d;
      done    <= done_d;
      result  <= result_d;
      cout    <= cout_d;
      busy    <= busy_d;
      add_a   <= add_a_d;
      add_b   <= add_b_d;
      add_cin <= add_cin_d;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: three instances (settle 2, 5, 1) each driving a delayed adder model.
// Settle-2 instance sees a 1-cycle adder, settle-5 and settle-1 instances see a 4-cycle adder.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_adder_share_arbiter;

  localparam int W = 16;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req, req5, req1;
  logic [4*W-1:0] a_in, b_in;
  logic [3:0]     cin_in;

  logic [3:0]   grant, grant5, grant1;
  logic         done, done5, done1;
  logic [W-1:0] result, result5, result1;
  logic         cout, cout5, cout1;
  logic         busy, busy5, busy1;
  logic [W-1:0] add_a, add_b, add_a5, add_b5, add_a1, add_b1;
  logic         add_cin, add_cin5, add_cin1;
  logic [W-1:0] add_sum, add_sum5, add_sum1;
  logic         add_cout, add_cout5, add_cout1;

  logic [W:0]   pm;
  logic [W:0]   p5 [4];
  logic [W:0]   p1 [4];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] ma [4];
  logic [W-1:0] mb [4];
  logic         mc [4];

  typedef struct {
    logic [3:0]   rq;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [3:0]   g;
    logic [W-1:0] res;
    logic         c;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .grant(grant), .done(done), .result(result), .cout(cout), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout));

  adder_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .grant(grant5), .done(done5), .result(result5), .cout(cout5), .busy(busy5),
    .add_a(add_a5), .add_b(add_b5), .add_cin(add_cin5), .add_sum(add_sum5), .add_cout(add_cout5));

  adder_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .grant(grant1), .done(done1), .result(result1), .cout(cout1), .busy(busy1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_sum(add_sum1), .add_cout(add_cout1));

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Adder models: the sum of the current inputs becomes visible only after the model's delay.
  always @(posedge clk) begin
    if (rst) begin
      pm <= '0;
      for (int k = 0; k < 4; k++) begin
        p5[k] <= '0;
        p1[k] <= '0;
      end
    end else begin
      pm    <= ref_add(add_a, add_b, add_cin);
      p5[0] <= ref_add(add_a5, add_b5, add_cin5);
      p1[0] <= ref_add(add_a1, add_b1, add_cin1);
      for (int k = 1; k < 4; k++) begin
        p5[k] <= p5[k-1];
        p1[k] <= p1[k-1];
      end
    end
  end
  assign add_sum   = pm[W-1:0];
  assign add_cout  = pm[W];
  assign add_sum5  = p5[3][W-1:0];
  assign add_cout5 = p5[3][W];
  assign add_sum1  = p1[3][W-1:0];
  assign add_cout1 = p1[3][W];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
    cin_in[i]      = c;
    ma[i] = a;
    mb[i] = b;
    mc[i] = c;
  endtask

  function automatic int idx_of(input logic [3:0] g);
    int r = 0;
    for (int k = 0; k < 4; k++) if (g[k]) r = k;
    return r;
  endfunction

  // Arbitration edge: expects grant g and operands of requester g on the adder inputs.
  task automatic start_op(input logic [3:0] g);
    int w;
    w = idx_of(g);
    tick();
    chk("grant_at_edge0", 32'(grant), 32'(g));
    chk("busy_at_edge0", 32'(busy), 32'd1);
    chk("done_at_edge0", 32'(done), 32'd0);
    chk("add_a", 32'(add_a), 32'(ma[w]));
    chk("add_b", 32'(add_b), 32'(mb[w]));
    chk("add_cin", 32'(add_cin), 32'(mc[w]));
  endtask

  // From after edge 0 through the return to idle after edge S+1.
  task automatic finish_op(input logic [3:0] g, input logic [W-1:0] r, input logic c, input bit drop);
    repeat (S - 1) begin
      tick();
      chk("done_early", 32'(done), 32'd0);
      chk("grant_held", 32'(grant), 32'(g));
    end
    tick();
    chk("done_pulse", 32'(done), 32'd1);
    chk("grant_at_done", 32'(grant), 32'(g));
    chk("result", 32'(result), 32'(r));
    chk("cout", 32'(cout), 32'(c));
    chk("busy_at_done", 32'(busy), 32'd1);
    if (drop) req = req & ~g;
    tick();
    chk("done_cleared", 32'(done), 32'd0);
    chk("grant_cleared", 32'(grant), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
  endtask

  task automatic do_op(input logic [3:0] g, input bit drop);
    logic [W:0] e;
    int w;
    w = idx_of(g);
    e = ref_add(ma[w], mb[w], mc[w]);
    start_op(g);
    finish_op(g, e[W-1:0], e[W], drop);
  endtask

  task automatic pulse_reset;
    req = '0; req5 = '0; req1 = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [W:0]   e;
    logic [3:0]   g;
    int           ptr_m;
    int           w;
    bit           drop;

    vecs[0] = '{4'b0001, 16'h1234, 16'h0101, 1'b0, 4'b0001, 16'h1335, 1'b0};
    vecs[1] = '{4'b0100, 16'hFFFF, 16'h0001, 1'b0, 4'b0100, 16'h0000, 1'b1};
    vecs[2] = '{4'b0100, 16'hFFFF, 16'hFFFF, 1'b1, 4'b0100, 16'hFFFF, 1'b1};
    vecs[3] = '{4'b1000, 16'h8000, 16'h8000, 1'b0, 4'b1000, 16'h0000, 1'b1};
    vecs[4] = '{4'b0010, 16'h0000, 16'h0000, 1'b1, 4'b0010, 16'h0001, 1'b0};
    vecs[5] = '{4'b0001, 16'h7FFF, 16'h0001, 1'b0, 4'b0001, 16'h8000, 1'b0};

    a_in = '0; b_in = '0; cin_in = '0;
    for (int i = 0; i < 4; i++) set_slot(i, '0, '0, 1'b0);
    pulse_reset();

    // Reset values.
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);

    // Idle with no requests holds.
    tick();
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Table of single-requester operations.
    for (int v = 0; v < 6; v++) begin
      set_slot(idx_of(vecs[v].g), vecs[v].a, vecs[v].b, vecs[v].cin);
      req = vecs[v].rq;
      start_op(vecs[v].g);
      finish_op(vecs[v].g, vecs[v].res, vecs[v].c, 1'b1);
    end

    // Round-robin across all four, then pointer wrap back to requester 0.
    pulse_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 16'h1000 * 16'(i + 1), 16'h0011 * 16'(i + 1), 1'(i));
    req = 4'b1111;
    do_op(4'b0001, 1'b1);
    do_op(4'b0010, 1'b1);
    do_op(4'b0100, 1'b1);
    do_op(4'b1000, 1'b1);
    req = 4'b1001;
    do_op(4'b0001, 1'b1);
    do_op(4'b1000, 1'b1);

    // Fairness: requester 0 never lets go, requester 2 still gets every other slot.
    req = 4'b0101;
    do_op(4'b0001, 1'b0);
    do_op(4'b0100, 1'b0);
    do_op(4'b0001, 1'b0);
    do_op(4'b0100, 1'b0);
    req = '0;
    tick();

    // Reset during DRIVE: no done, outputs cleared, pointer back to 0.
    set_slot(1, 16'h00F0, 16'h0F00, 1'b1);
    req = 4'b0010;
    start_op(4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = '0;
    chk("abort_grant", 32'(grant), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_add_a", 32'(add_a), 32'd0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    for (int i = 1; i < 4; i++) set_slot(i, 16'h0100 * 16'(i), 16'h0003, 1'b0);
    req = 4'b1110;
    do_op(4'b0010, 1'b1);
    req = '0;
    tick();

    // Settle 5 against a 4-cycle adder: correct sum captured on edge 5.
    set_slot(0, 16'h1234, 16'h0101, 1'b0);
    req5 = 4'b0001;
    tick();
    chk("s5_grant", 32'(grant5), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("s5_done_early", 32'(done5), 32'd0);
    end
    tick();
    chk("s5_done", 32'(done5), 32'd1);
    chk("s5_result", 32'(result5), 32'h1335);
    chk("s5_cout", 32'(cout5), 32'd0);
    req5 = '0;
    tick();
    chk("s5_grant_cleared", 32'(grant5), 32'd0);

    // Settle 1 against the same adder: samples the stale zero sum on edge 1.
    req1 = 4'b0001;
    tick();
    chk("s1_grant", 32'(grant1), 32'd1);
    tick();
    chk("s1_done", 32'(done1), 32'd1);
    chk("s1_stale_result", 32'(result1), 32'h0000);
    req1 = '0;
    tick();

    // Randomized traffic against a transaction-level round-robin model.
    pulse_reset();
    ptr_m = 0;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && ($urandom_range(0, 2) == 0)) begin
          set_slot(i, 16'($urandom), 16'($urandom), 1'($urandom));
          req[i] = 1'b1;
        end
      end
      if (req == 4'b0000) begin
        tick();
        chk("rnd_idle_grant", 32'(grant), 32'd0);
        chk("rnd_idle_done", 32'(done), 32'd0);
        continue;
      end
      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && req[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
      end
      g = 4'b0001 << w;
      e = ref_add(ma[w], mb[w], mc[w]);
      start_op(g);
      // Operands are free to change once captured.
      set_slot(w, 16'($urandom), 16'($urandom), 1'($urandom));
      drop = ($urandom_range(0, 3) != 0);
      finish_op(g, e[W-1:0], e[W], drop);
      ptr_m = (w + 1) % 4;
    end
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 16-bit ripple-carry adder (rc_adder16) among 4 requesters. It registers the winning requester's operands onto the adder inputs and holds them for a programmable settle time, so the gate-level ripple chain can resolve. It then captures sum/carry and returns them with a one-cycle done pulse. It sits between the requesting datapath blocks and the single adder instance.

Parameters:
WIDTH, 16, operand/sum width; must match the adder instance.
SETTLE_CYCLES, 2, clock cycles the adder inputs are held before sampling; legal range 1..15; 0 is illegal.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
req  input  4  request per requester, level; held high until done
a_in  input  4*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH]
b_in  input  4*WIDTH  operand B, same packing
cin_in  input  4  carry-in per requester
grant  output  4  one-hot index of the requester being served; 0 when idle
done  output  1  one-cycle pulse: result/cout valid for the granted requester
result  output  WIDTH  captured sum
cout  output  1  captured carry-out
busy  output  1  high in DRIVE and DONE
add_a  output  WIDTH  to adder a
add_b  output  WIDTH  to adder b
add_cin  output  1  to adder carry_in
add_sum  input  WIDTH  from adder sum
add_cout  input  1  from adder carry_out

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: grant=0, done=0, result=0, cout=0, busy=0, add_a=0, add_b=0, add_cin=0. Internal state: state=IDLE, rr_ptr=0, cnt=0.
- State machine: IDLE -> DRIVE -> DONE -> IDLE.
- IDLE, any req bit set at the clock edge:
  - Winner = first set bit searching rr_ptr, rr_ptr+1, ... modulo 4. After reset the search order is 0,1,2,3.
  - On that edge: grant=onehot(winner), add_a/add_b/add_cin loaded from the winner's slice, cnt=SETTLE_CYCLES-1, busy=1, state=DRIVE, rr_ptr=(winner+1) mod 4.
- IDLE with req=0: hold; outputs unchanged except done=0.
- DRIVE:
  - Adder inputs held constant.
  - cnt!=0: cnt decrements.
  - cnt==0: on that edge result=add_sum, cout=add_cout, done=1, state=DONE.
- DONE (exactly one cycle): done=1, grant still valid. Next edge: done=0, grant=0, busy=0, state=IDLE. add_a/add_b/add_cin keep their last values.
- Latency: the edge that samples req in IDLE is edge 0. done is high in the cycle after edge SETTLE_CYCLES. The next arbitration edge is SETTLE_CYCLES+2. Throughput is one operation per SETTLE_CYCLES+2 cycles.
- Requester contract:
  - Hold req until done is seen with its grant bit set, then drop it.
  - Operands may change freely after the sampling edge, because they are captured at grant.
  - A requester that keeps req high is re-arbitrated normally; the round-robin pointer has already moved past it.
- Req dropped during DRIVE: the operation completes, done still pulses with the same grant, and the result is discarded by the requester.
- Simultaneous requests: strictly round-robin. No requester waits more than 3 other operations.
- Arithmetic: result = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. No saturation.
- rst during DRIVE or DONE: aborts immediately to reset values. No done pulse and no result update. rr_ptr returns to 0.
- Unused req bits at X: treated as don't-care only when not selected; the bench drives all bits to known values.

Test Plan:
- Single request: req=0001, a=0x1234, b=0x0101, cin=0, SETTLE=2 -> grant=0001 after edge 0; done high in the cycle after edge 2; result=0x1335, cout=0; grant=0 after edge 3.
- Overflow: req=0100, a=0xFFFF, b=0x0001, cin=0 -> result=0x0000, cout=1. Then a=0xFFFF, b=0xFFFF, cin=1 -> result=0xFFFF, cout=1.
- Round-robin: all req=1111 held, each dropping its req on its own done -> grant order 0001, 0010, 0100, 1000. Then with req=1001 re-raised -> next grant=0001 (pointer wrapped).
- Fairness: req0 held continuously, req2 asserted -> grants alternate 0001, 0100, 0001, ...; req2 is never skipped.
- Settle parameter: SETTLE_CYCLES=5, adder model with a 4-cycle ripple delay -> correct sum captured exactly 5 edges after the grant edge. With SETTLE_CYCLES=1 and the same model -> bench detects a wrong value, confirming that sampling occurs on that edge.
- Reset mid-op: rst pulsed one cycle during DRIVE -> no done pulse, all outputs 0 next cycle. A subsequent req=1110 grants 0010 (pointer reset to 0).
